ps2_decodificador_eventos: RTL and testbench
============================================

Name: ps2_decodificador_eventos

Overview:
- Sits directly downstream of the PS/2 byte receiver and upstream of the key-to-code converter.
- Consumes received scan-code bytes, strips E0 (extended) and F0 (break) prefixes, and assembles complete key events {ext, brk, code}.
- Buffers events in a small FIFO and throttles the receiver's rx_en when the FIFO is full.

Parameters:
- PROF_FIFO, 4, FIFO depth in events; power of 2, minimum 2.
- AW, 2, address width; must equal log2(PROF_FIFO).

Ports:
- clk_i  in  1  system clock (100 MHz board clock).
- rst_i  in  1  asynchronous, active-low reset.
- rx_listo_i  in  1  one-cycle pulse: dato_i holds a new, parity-checked byte.
- dato_i  in  8  received byte (receiver data bits [8:1]).
- evt_rd_i  in  1  pop request for the head event.
- clr_err_i  in  1  synchronous clear of the sticky error flags.
- evt_codigo_o  out  8  head event scan code.
- evt_ext_o  out  1  head event was E0-prefixed.
- evt_brk_o  out  1  head event is a key release (F0-prefixed).
- evt_valido_o  out  1  FIFO not empty; head outputs are valid.
- evt_lleno_o  out  1  FIFO full.
- rx_en_o  out  1  receiver enable; equals ~evt_lleno_o.
- err_proto_o  out  1  sticky flag: illegal prefix sequence seen.
- err_ovf_o  out  1  sticky flag: event dropped because the FIFO was full.

Behaviour:
- Reset (rst_i=0, asynchronous): FSM to S_IDLE, FIFO pointers and count to 0, all event outputs 0, evt_valido_o=0, evt_lleno_o=0, rx_en_o=1, both error flags 0.
- Bytes are sampled only on clock edges where rx_listo_i=1; dato_i is ignored otherwise.
- FSM states: S_IDLE, S_EXT, S_BRK, S_EXT_BRK (2-bit encoding). Transitions per sampled byte:
  - S_IDLE: E0 -> S_EXT; F0 -> S_BRK; AA (BAT) or FA (ACK) -> dropped, stay in S_IDLE; any other byte -> push {0,0,byte}.
  - S_EXT: F0 -> S_EXT_BRK; E0 -> set err_proto, stay in S_EXT; other -> push {1,0,byte}, go to S_IDLE.
  - S_BRK: E0 or F0 -> set err_proto, go to S_IDLE, nothing pushed; other -> push {0,1,byte}, go to S_IDLE.
  - S_EXT_BRK: E0 or F0 -> set err_proto, go to S_IDLE; other -> push {1,1,byte}, go to S_IDLE.
- FIFO is show-ahead: head fields drive evt_* combinationally from registered storage.
  - Latency: a push on edge N gives evt_valido_o=1 after edge N when the FIFO was empty.
- Pop occurs when evt_rd_i=1 and the FIFO is not empty; pop while empty is ignored (no underflow, no flag).
- Push while full and no pop on the same edge: event dropped, err_ovf set, contents unchanged.
- Simultaneous push and pop:
  - When full: both take effect, count unchanged, no overflow.
  - When empty: only the push takes effect.
- Output values when empty: evt_codigo_o, evt_ext_o and evt_brk_o read 0.
- Pointers wrap modulo PROF_FIFO. The count is AW+1 bits; full when count == PROF_FIFO.
- rx_en_o is registered from the next-state count, so it is low in the same cycle evt_lleno_o rises.
- Error flags:
  - Set on the offending edge; cleared by clr_err_i or reset.
  - Set has priority over clear on the same edge.
- Reset asserted mid-prefix (after E0 or F0) discards the pending prefix. The next plain byte produces {0,0,byte}.

Decomposition:
- Shared package (ps2_pkg) holds:
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA, PS2_ACK=8'hFA;
  - the FSM state encodings;
  - the event width constant EVT_W=10.
- One natural sub-module: fifo_eventos, a generic synchronous show-ahead FIFO (width EVT_W, depth PROF_FIFO) with full/empty and count. The prefix FSM and error flags stay in the parent.

Test Plan:
- Send 1C -> one event: code=1C, ext=0, brk=0; evt_valido_o=1 one cycle after the rx_listo_i edge. Pop -> evt_valido_o=0.
- Send F0, 1C -> single event: code=1C, brk=1, ext=0; the F0 byte alone produces no event.
- Send E0, F0, 75 then E0, 75 -> two events in order: {75, ext=1, brk=1} then {75, ext=1, brk=0}.
- Send five plain bytes 15,1D,24,2D,2C with no pops (PROF_FIFO=4):
  - evt_lleno_o=1 and rx_en_o=0 after the 4th byte;
  - 2C dropped, err_ovf_o=1;
  - popping returns 15,1D,24,2D.
  - Then fill to full and issue push+pop on the same edge -> count stays 4, no new overflow.
- Protocol errors:
  - Send F0, E0, 1C -> err_proto_o=1, then event {1C, 0, 0}. Pulse clr_err_i -> err_proto_o=0.
  - Send AA -> no event, no error.
- Send E0, assert rst_i=0 mid-stream for 3 cycles, release, send 1C -> event {1C, ext=0, brk=0}; all flags 0 after reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PS/2 key-event decoder:
//   - special scan-code bytes (extended prefix, break prefix, BAT, ACK)
//   - prefix FSM state encoding
//   - packed key-event layout {ext, brk, code} and helpers to build/test it
// No ports (package).
// -----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_BAT = 8'hAA;
    localparam logic [7:0] PS2_ACK = 8'hFA;

    // Event word: bit 9 = ext, bit 8 = brk, bits 7:0 = scan code
    localparam int EVT_W = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_EXT     = 2'b01,
        S_BRK     = 2'b10,
        S_EXT_BRK = 2'b11
    } estado_t;

    function automatic logic [EVT_W-1:0] empaqueta_evento(
        input logic       ext,
        input logic       brk,
        input logic [7:0] codigo
    );
        return {ext, brk, codigo};
    endfunction

    // True for either prefix byte; a prefix arriving where a code is
    // required is a protocol error.
    function automatic logic es_prefijo(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_decodificador_eventos_fifo.sv
// -----------------------------------------------------------------------------
// fifo_eventos
// Generic synchronous show-ahead FIFO. The head word is driven
// combinationally from storage and reads as zero while empty.
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-low reset (pointers and count)
//   i_push        write request; ignored when full unless i_pop is also set
//   i_pop         read request; ignored when empty
//   i_dato        write data
//   o_dato        head word (0 when empty)
//   o_vacio       FIFO empty
//   o_cuenta      current occupancy (AW+1 bits)
//   o_cuenta_sig  occupancy after the current edge (for registered flags)
// -----------------------------------------------------------------------------
module fifo_eventos
    import ps2_pkg::*;
#(
    parameter int W    = EVT_W,
    parameter int PROF = 4,
    parameter int AW   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_dato,
    output logic [W-1:0]  o_dato,
    output logic          o_vacio,
    output logic [AW:0]   o_cuenta,
    output logic [AW:0]   o_cuenta_sig
);

    localparam logic [AW:0] CUENTA_LLENO = (AW+1)'(PROF);

    logic [W-1:0]  r_mem [PROF];
    logic [AW-1:0] r_ptr_wr;
    logic [AW-1:0] r_ptr_rd;
    logic [AW:0]   r_cuenta;

    logic          w_vacio;
    logic          w_lleno;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [AW:0]   w_cuenta_sig;

    assign w_vacio = (r_cuenta == '0);
    assign w_lleno = (r_cuenta == CUENTA_LLENO);

    // A full FIFO still accepts a write when the head leaves on the same
    // edge; an empty FIFO never pops, so push+pop while empty is a push.
    assign w_push_ok = i_push & (~w_lleno | i_pop);
    assign w_pop_ok  = i_pop & ~w_vacio;

    always_comb begin
        w_cuenta_sig = r_cuenta;
        if (w_push_ok && !w_pop_ok) begin
            w_cuenta_sig = r_cuenta + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_cuenta_sig = r_cuenta - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr_wr <= '0;
            r_ptr_rd <= '0;
            r_cuenta <= '0;
        end else begin
            // Pointers wrap naturally because PROF == 2**AW
            if (w_push_ok) r_ptr_wr <= r_ptr_wr + 1'b1;
            if (w_pop_ok)  r_ptr_rd <= r_ptr_rd + 1'b1;
            r_cuenta <= w_cuenta_sig;
        end
    end

    // Storage carries no reset; the empty gate on o_dato hides stale words.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_ptr_wr] <= i_dato;
        end
    end

    assign o_dato       = w_vacio ? '0 : r_mem[r_ptr_rd];
    assign o_vacio      = w_vacio;
    assign o_cuenta     = r_cuenta;
    assign o_cuenta_sig = w_cuenta_sig;

endmodule

// File: rtl/ps2_decodificador_eventos.sv
// -----------------------------------------------------------------------------
// ps2_decodificador_eventos
// Turns the PS/2 receiver's byte stream into key events {ext, brk, code}:
// strips E0/F0 prefixes with a small FSM, drops BAT/ACK bytes, queues events
// in a show-ahead FIFO and throttles the receiver while the FIFO is full.
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-low reset
//   rx_listo_i    one-cycle strobe: dato_i holds a new byte
//   dato_i        received byte
//   evt_rd_i      pop the head event
//   clr_err_i     clear sticky error flags (a same-edge set wins)
//   evt_codigo_o  head event scan code (0 when empty)
//   evt_ext_o     head event had an E0 prefix
//   evt_brk_o     head event is a release (F0 prefix)
//   evt_valido_o  FIFO not empty
//   evt_lleno_o   FIFO full
//   rx_en_o       receiver enable, low while full
//   err_proto_o   sticky: illegal prefix sequence
//   err_ovf_o     sticky: event dropped on a full FIFO
// -----------------------------------------------------------------------------
module ps2_decodificador_eventos
    import ps2_pkg::*;
#(
    parameter int PROF_FIFO = 4,
    parameter int AW        = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_listo_i,
    input  logic [7:0] dato_i,
    input  logic       evt_rd_i,
    input  logic       clr_err_i,
    output logic [7:0] evt_codigo_o,
    output logic       evt_ext_o,
    output logic       evt_brk_o,
    output logic       evt_valido_o,
    output logic       evt_lleno_o,
    output logic       rx_en_o,
    output logic       err_proto_o,
    output logic       err_ovf_o
);

    localparam logic [AW:0] CUENTA_LLENO = (AW+1)'(PROF_FIFO);

    estado_t          r_estado;
    estado_t          w_estado_sig;

    logic             w_push;
    logic [EVT_W-1:0] w_evt;
    logic             w_set_proto;
    logic             w_set_ovf;

    logic [EVT_W-1:0] w_cabeza;
    logic             w_vacio;
    logic             w_lleno;
    logic [AW:0]      w_cuenta;
    logic [AW:0]      w_cuenta_sig;

    logic             r_err_proto;
    logic             r_err_ovf;
    logic             r_rx_en;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_estado <= S_IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // FSM next state: only sampled bytes move the FSM
    always_comb begin
        w_estado_sig = r_estado;
        if (rx_listo_i) begin
            unique case (r_estado)
                S_IDLE: begin
                    if (dato_i == PS2_EXT)      w_estado_sig = S_EXT;
                    else if (dato_i == PS2_BRK) w_estado_sig = S_BRK;
                    else                        w_estado_sig = S_IDLE;
                end
                S_EXT: begin
                    // A repeated E0 is flagged but keeps the extended prefix
                    if (dato_i == PS2_BRK)      w_estado_sig = S_EXT_BRK;
                    else if (dato_i == PS2_EXT) w_estado_sig = S_EXT;
                    else                        w_estado_sig = S_IDLE;
                end
                S_BRK:     w_estado_sig = S_IDLE;
                S_EXT_BRK: w_estado_sig = S_IDLE;
                default:   w_estado_sig = S_IDLE;
            endcase
        end
    end

    // FSM outputs: event push and protocol-error strobe
    always_comb begin
        w_push      = 1'b0;
        w_evt       = '0;
        w_set_proto = 1'b0;
        if (rx_listo_i) begin
            unique case (r_estado)
                S_IDLE: begin
                    if (!es_prefijo(dato_i) && dato_i != PS2_BAT && dato_i != PS2_ACK) begin
                        w_push = 1'b1;
                        w_evt  = empaqueta_evento(1'b0, 1'b0, dato_i);
                    end
                end
                S_EXT: begin
                    if (dato_i == PS2_EXT) begin
                        w_set_proto = 1'b1;
                    end else if (dato_i != PS2_BRK) begin
                        w_push = 1'b1;
                        w_evt  = empaqueta_evento(1'b1, 1'b0, dato_i);
                    end
                end
                S_BRK: begin
                    if (es_prefijo(dato_i)) begin
                        w_set_proto = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_evt  = empaqueta_evento(1'b0, 1'b1, dato_i);
                    end
                end
                S_EXT_BRK: begin
                    if (es_prefijo(dato_i)) begin
                        w_set_proto = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        w_evt  = empaqueta_evento(1'b1, 1'b1, dato_i);
                    end
                end
                default: begin
                    w_push = 1'b0;
                end
            endcase
        end
    end

    fifo_eventos #(
        .W    (EVT_W),
        .PROF (PROF_FIFO),
        .AW   (AW)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_push       (w_push),
        .i_pop        (evt_rd_i),
        .i_dato       (w_evt),
        .o_dato       (w_cabeza),
        .o_vacio      (w_vacio),
        .o_cuenta     (w_cuenta),
        .o_cuenta_sig (w_cuenta_sig)
    );

    assign w_lleno = (w_cuenta == CUENTA_LLENO);

    // A pop on the same edge makes room, so that case is not an overflow
    assign w_set_ovf = w_push & w_lleno & ~evt_rd_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err_proto <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_rx_en     <= 1'b1;
        end else begin
            if (w_set_proto)    r_err_proto <= 1'b1;
            else if (clr_err_i) r_err_proto <= 1'b0;

            if (w_set_ovf)      r_err_ovf <= 1'b1;
            else if (clr_err_i) r_err_ovf <= 1'b0;

            // Registered from the next count so it drops together with full
            r_rx_en <= (w_cuenta_sig != CUENTA_LLENO);
        end
    end

    assign evt_ext_o    = w_cabeza[9];
    assign evt_brk_o    = w_cabeza[8];
    assign evt_codigo_o = w_cabeza[7:0];
    assign evt_valido_o = ~w_vacio;
    assign evt_lleno_o  = w_lleno;
    assign rx_en_o      = r_rx_en;
    assign err_proto_o  = r_err_proto;
    assign err_ovf_o    = r_err_ovf;

endmodule

// File: tb/tb_ps2_decodificador_eventos.sv
// -----------------------------------------------------------------------------
// tb_ps2_decodificador_eventos
// Directed bench for the PS/2 key-event decoder. Inputs change on the falling
// edge and outputs are sampled on the falling edge after the active edge.
// -----------------------------------------------------------------------------
module tb_ps2_decodificador_eventos;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_listo_i;
    logic [7:0] dato_i;
    logic       evt_rd_i;
    logic       clr_err_i;
    logic [7:0] evt_codigo_o;
    logic       evt_ext_o;
    logic       evt_brk_o;
    logic       evt_valido_o;
    logic       evt_lleno_o;
    logic       rx_en_o;
    logic       err_proto_o;
    logic       err_ovf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ps2_decodificador_eventos #(
        .PROF_FIFO (4),
        .AW        (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_listo_i   (rx_listo_i),
        .dato_i       (dato_i),
        .evt_rd_i     (evt_rd_i),
        .clr_err_i    (clr_err_i),
        .evt_codigo_o (evt_codigo_o),
        .evt_ext_o    (evt_ext_o),
        .evt_brk_o    (evt_brk_o),
        .evt_valido_o (evt_valido_o),
        .evt_lleno_o  (evt_lleno_o),
        .rx_en_o      (rx_en_o),
        .err_proto_o  (err_proto_o),
        .err_ovf_o    (err_ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [7:0] cod, input logic ext, input logic brk);
        chk({tag, "_valido"}, {31'd0, evt_valido_o}, 32'd1);
        chk({tag, "_codigo"}, {24'd0, evt_codigo_o}, {24'd0, cod});
        chk({tag, "_ext"},    {31'd0, evt_ext_o},    {31'd0, ext});
        chk({tag, "_brk"},    {31'd0, evt_brk_o},    {31'd0, brk});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_i);
        rx_listo_i = 1'b1;
        dato_i     = b;
        @(negedge clk_i);
        rx_listo_i = 1'b0;
        dato_i     = 8'h00;
    endtask

    task automatic pop();
        @(negedge clk_i);
        evt_rd_i = 1'b1;
        @(negedge clk_i);
        evt_rd_i = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk_i);
        clr_err_i = 1'b1;
        @(negedge clk_i);
        clr_err_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b0;
        rx_listo_i = 1'b0;
        dato_i     = 8'h00;
        evt_rd_i   = 1'b0;
        clr_err_i  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_valido", {31'd0, evt_valido_o}, 32'd0);
        chk("rst_lleno",  {31'd0, evt_lleno_o},  32'd0);
        chk("rst_rx_en",  {31'd0, rx_en_o},      32'd1);
        chk("rst_proto",  {31'd0, err_proto_o},  32'd0);
        chk("rst_ovf",    {31'd0, err_ovf_o},    32'd0);
        chk("rst_codigo", {24'd0, evt_codigo_o}, 32'd0);
        rst_i = 1'b1;

        // Plain make code, then pop
        send(8'h1C);
        chk_head("plain", 8'h1C, 1'b0, 1'b0);
        pop();
        chk("plain_pop_valido", {31'd0, evt_valido_o}, 32'd0);
        chk("plain_pop_codigo", {24'd0, evt_codigo_o}, 32'd0);

        // Break code: F0 alone makes no event
        send(8'hF0);
        chk("brk_prefix_valido", {31'd0, evt_valido_o}, 32'd0);
        send(8'h1C);
        chk_head("brk", 8'h1C, 1'b0, 1'b1);
        pop();

        // Extended break followed by extended make
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'hE0);
        send(8'h75);
        chk_head("extbrk", 8'h75, 1'b1, 1'b1);
        pop();
        chk_head("ext", 8'h75, 1'b1, 1'b0);
        pop();
        chk("ext_pop_valido", {31'd0, evt_valido_o}, 32'd0);
        chk("ext_proto",      {31'd0, err_proto_o},  32'd0);

        // Fill to full and overflow
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        chk("fill3_lleno", {31'd0, evt_lleno_o}, 32'd0);
        chk("fill3_rx_en", {31'd0, rx_en_o},     32'd1);
        send(8'h2D);
        chk("fill4_lleno", {31'd0, evt_lleno_o}, 32'd1);
        chk("fill4_rx_en", {31'd0, rx_en_o},     32'd0);
        chk("fill4_ovf",   {31'd0, err_ovf_o},   32'd0);
        send(8'h2C);
        chk("ovf_flag",  {31'd0, err_ovf_o},   32'd1);
        chk("ovf_lleno", {31'd0, evt_lleno_o}, 32'd1);
        chk_head("ovf_head0", 8'h15, 1'b0, 1'b0);
        pop();
        chk("ovf_pop_lleno", {31'd0, evt_lleno_o}, 32'd0);
        chk("ovf_pop_rx_en", {31'd0, rx_en_o},     32'd1);
        chk_head("ovf_head1", 8'h1D, 1'b0, 1'b0);
        pop();
        chk_head("ovf_head2", 8'h24, 1'b0, 1'b0);
        pop();
        chk_head("ovf_head3", 8'h2D, 1'b0, 1'b0);
        pop();
        chk("ovf_drain_valido", {31'd0, evt_valido_o}, 32'd0);
        chk("ovf_still_set",    {31'd0, err_ovf_o},    32'd1);
        clr_pulse();
        chk("ovf_clr", {31'd0, err_ovf_o}, 32'd0);

        // Full FIFO with push and pop on the same edge
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        chk("pp_full_before", {31'd0, evt_lleno_o}, 32'd1);
        @(negedge clk_i);
        rx_listo_i = 1'b1;
        dato_i     = 8'h05;
        evt_rd_i   = 1'b1;
        @(negedge clk_i);
        rx_listo_i = 1'b0;
        dato_i     = 8'h00;
        evt_rd_i   = 1'b0;
        chk("pp_lleno", {31'd0, evt_lleno_o}, 32'd1);
        chk("pp_rx_en", {31'd0, rx_en_o},     32'd0);
        chk("pp_ovf",   {31'd0, err_ovf_o},   32'd0);
        chk_head("pp_head0", 8'h02, 1'b0, 1'b0);
        pop();
        chk_head("pp_head1", 8'h03, 1'b0, 1'b0);
        pop();
        chk_head("pp_head2", 8'h04, 1'b0, 1'b0);
        pop();
        chk_head("pp_head3", 8'h05, 1'b0, 1'b0);
        pop();
        chk("pp_drain_valido", {31'd0, evt_valido_o}, 32'd0);

        // Pop while empty is ignored
        pop();
        chk("empty_pop_valido", {31'd0, evt_valido_o}, 32'd0);
        chk("empty_pop_lleno",  {31'd0, evt_lleno_o},  32'd0);

        // Protocol error: F0 then E0, then a plain byte
        send(8'hF0);
        chk("proto_before", {31'd0, err_proto_o}, 32'd0);
        send(8'hE0);
        chk("proto_set",    {31'd0, err_proto_o},  32'd1);
        chk("proto_no_evt", {31'd0, evt_valido_o}, 32'd0);
        send(8'h1C);
        chk_head("proto_evt", 8'h1C, 1'b0, 1'b0);
        pop();
        clr_pulse();
        chk("proto_clr", {31'd0, err_proto_o}, 32'd0);

        // BAT and ACK are dropped silently
        send(8'hAA);
        chk("bat_valido", {31'd0, evt_valido_o}, 32'd0);
        chk("bat_proto",  {31'd0, err_proto_o},  32'd0);
        send(8'hFA);
        chk("ack_valido", {31'd0, evt_valido_o}, 32'd0);

        // Double E0 flags an error and stays extended
        send(8'hE0);
        send(8'hE0);
        chk("ee_proto", {31'd0, err_proto_o}, 32'd1);
        send(8'h6B);
        chk_head("ee_evt", 8'h6B, 1'b1, 1'b0);
        pop();

        // Reset in the middle of a prefix discards it
        send(8'hE0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("arst_proto",  {31'd0, err_proto_o},  32'd0);
        chk("arst_valido", {31'd0, evt_valido_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("arst_ovf",   {31'd0, err_ovf_o},   32'd0);
        chk("arst_rx_en", {31'd0, rx_en_o},     32'd1);
        chk("arst_lleno", {31'd0, evt_lleno_o}, 32'd0);
        rst_i = 1'b1;
        send(8'h1C);
        chk_head("arst_evt", 8'h1C, 1'b0, 1'b0);
        pop();
        chk("arst_pop_valido", {31'd0, evt_valido_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
